// File: rtl/seg_scan_mux_if.sv
// Load handshake bundle for seg_scan_mux: packed hex value plus valid/ready.
// The producer uses the master modport; the scan driver uses slave.
interface seg_scan_mux_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();

  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load_valid;
  logic                    load_ready;

  modport master (
    output value_in,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  value_in,
    input  load_valid,
    output load_ready
  );

endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan driver for an N-digit seven-segment display with frame-synchronous
// value updates. Optional feature macro: SEG_LEADING_ZERO_BLANK_EN (suppress leading zeros).
`ifndef CLK_FREQ
`define CLK_FREQ 50_000_000
`endif

module seg_scan_mux #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_FREQ_HZ  = `CLK_FREQ,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_scan_mux_if.slave         load,
  output logic [3:0]            hex,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_start
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / REFRESH_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    StBlank,
    StShow
  } state_e;

  // With no blanking cycles the slot is all SHOW, including straight out of reset.
  localparam state_e ST_RESET = (BLANK_CYCLES == 0) ? StShow : StBlank;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  state_e                state_q, state_d;
  logic [VAL_W-1:0]      display_q, display_d;
  logic [VAL_W-1:0]      pending_q, pending_d;
  logic                  pend_full_q, pend_full_d;
  logic [3:0]            hex_q, hex_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  frame_start_q, frame_start_d;

  logic                  wrap;
  logic                  boundary;
  logic                  xfer;
  logic [NUM_DIGITS-1:0] show_mask;
  logic [NUM_DIGITS-1:0] onehot;

  assign wrap     = (cnt_q == CNT_MAX);
  assign boundary = wrap && (idx_q == IDX_MAX);
  assign xfer     = load.load_valid && !pend_full_q;

  // Slot counter and digit index.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (wrap) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Per-slot phase: blank first, then show until the counter wraps.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBlank: if (cnt_d >= CNT_BLANK) state_d = StShow;
      StShow:  if (wrap && (BLANK_CYCLES != 0)) state_d = StBlank;
      default: state_d = ST_RESET;
    endcase
  end

  // Pending/display double buffer. A transfer needs pending empty, so it can never collide
  // with a boundary that drains pending in the same cycle.
  always_comb begin
    display_d   = display_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    if (boundary && pend_full_q) begin
      display_d   = pending_q;
      pend_full_d = 1'b0;
    end
    if (xfer) begin
      pending_d   = load.value_in;
      pend_full_d = 1'b1;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Digit k>0 is suppressed when it and every more significant nibble are zero.
  always_comb begin
    show_mask    = '0;
    show_mask[0] = 1'b1;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      show_mask[k] = |(display_d >> (4 * k));
    end
  end
`else
  assign show_mask = '1;
`endif

  // Outputs are registered from next-state so they line up with the slot they describe.
  always_comb begin
    onehot        = NUM_DIGITS'(1) << idx_d;
    hex_d         = display_d[{idx_d, 2'b00} +: 4];
    dig_en_d      = (state_d == StShow) ? (onehot & show_mask) : '0;
    frame_start_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      state_q       <= ST_RESET;
      display_q     <= '0;
      pending_q     <= '0;
      pend_full_q   <= 1'b0;
      hex_q         <= '0;
      dig_en_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      state_q       <= state_d;
      display_q     <= display_d;
      pending_q     <= pending_d;
      pend_full_q   <= pend_full_d;
      hex_q         <= hex_d;
      dig_en_q      <= dig_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign load.load_ready = ~pend_full_q;
  assign hex             = hex_q;
  assign dig_en          = dig_en_q;
  assign frame_start     = frame_start_q;

  a_dig_en_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(dig_en));
  a_frame_on_digit0: assert property (@(posedge clk) disable iff (!rst_n)
                                      frame_start |-> (dig_en[NUM_DIGITS-1:1] == '0));

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: a cycle-indexed reference model pushes expected outputs
// when inputs are driven; they are popped and compared on the following falling edge.
module tb_seg_scan_mux;

  localparam int unsigned ND = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    hex;
  logic [ND-1:0] dig_en;
  logic          frame_start;

  always #5 clk = ~clk;

  seg_scan_mux_if #(.NUM_DIGITS(ND)) lif ();

  seg_scan_mux #(
    .NUM_DIGITS  (ND),
    .CLK_FREQ_HZ (1000),
    .REFRESH_HZ  (100),
    .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (lif),
    .hex        (hex),
    .dig_en     (dig_en),
    .frame_start(frame_start)
  );

  typedef struct packed {
    logic [3:0]    hex;
    logic [ND-1:0] en;
    logic          fs;
    logic          rdy;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: cycles since reset release fix the slot/digit; buffers tracked per edge.
  int          t = 0;
  bit          m_ok = 1'b0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic        m_full = 1'b0;

  int         ph = 0;
  int         show_cnt = 0;
  int         fs_cnt = 0;
  logic [3:0] en_or1 = '0;
  logic [3:0] en_or2 = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0d: got %0h, expected %0h", tag, t, got, exp);
  endtask

  function automatic exp_t model_out();
    exp_t        e;
    int          cnt;
    int          idx;
    logic [15:0] sh;
    cnt   = t % 10;
    idx   = (t / 10) % 4;
    sh    = m_disp >> (4 * idx);
    e.hex = sh[3:0];
    e.en  = (cnt >= 2) ? 4'(1 << idx) : 4'b0000;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (idx > 0 && sh == 16'h0000) e.en = 4'b0000;
`endif
    e.fs  = (t > 0) && (t % 40 == 0);
    e.rdy = !m_full;
    return e;
  endfunction

  task automatic step(input logic rn, input logic lv, input logic [15:0] val);
    exp_t e;
    bit   bnd;
    bit   xf;
    @(negedge clk);
    rst_n          = rn;
    lif.load_valid = lv;
    lif.value_in   = val;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("hex", 32'(hex), 32'(e.hex));
      check_eq("dig_en", 32'(dig_en), 32'(e.en));
      check_eq("frame_start", 32'(frame_start), 32'(e.fs));
      check_eq("load_ready", 32'(lif.load_ready), 32'(e.rdy));
      if (ph == 1 && t >= 40 && t < 80 && dig_en != '0) show_cnt++;
      if (ph == 1 && frame_start) fs_cnt++;
      if (ph == 4 && t >= 80 && t < 160) en_or1 |= dig_en;
      if (ph == 4 && t >= 200 && t < 250) en_or2 |= dig_en;
    end
    @(posedge clk);
    if (!rn) begin
      m_ok   = 1'b1;
      t      = 0;
      m_disp = '0;
      m_pend = '0;
      m_full = 1'b0;
    end else if (m_ok) begin
      bnd = (t % 40 == 39);
      xf  = lv && !m_full;
      if (bnd && m_full) begin
        m_disp = m_pend;
        m_full = 1'b0;
      end
      if (xf) begin
        m_pend = val;
        m_full = 1'b1;
      end
      t++;
    end
    if (m_ok) sb.push_back(model_out());
  endtask

  task automatic run_to(input int tt);
    int guard;
    guard = 0;
    while (t < tt && guard < 1000) begin
      step(1'b1, 1'b0, 16'h0000);
      guard++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    lif.load_valid = 1'b0;
    lif.value_in   = '0;

    repeat (3) step(1'b0, 1'b0, 16'h0000);

    // Mid-frame load; count SHOW cycles and frame pulses over the first frames.
    ph = 1;
    run_to(15);
    step(1'b1, 1'b1, 16'h1A3F);
    run_to(95);
    check_eq("show_cycles_per_frame", 32'(show_cnt), 32'd32);
    check_eq("frame_start_count", 32'(fs_cnt), 32'd2);

    // Back-to-back: second value offered while not ready must be ignored.
    ph = 2;
    step(1'b1, 1'b1, 16'h1234);
    repeat (5) step(1'b1, 1'b1, 16'h5678);
    run_to(125);
    step(1'b1, 1'b1, 16'h5678);

    // Load exactly in the frame-boundary cycle with pending empty.
    run_to(199);
    step(1'b1, 1'b1, 16'hABCD);

    // Reset during digit 2's SHOW with a value pending.
    ph = 3;
    run_to(292);
    step(1'b1, 1'b1, 16'h4321);
    run_to(305);
    repeat (2) step(1'b0, 1'b0, 16'h0000);
    run_to(60);

    // Leading-zero cases.
    ph = 4;
    step(1'b1, 1'b1, 16'h0040);
    run_to(160);
    step(1'b1, 1'b1, 16'h0000);
    run_to(250);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    check_eq("lzb_0040_digits", 32'(en_or1), 32'h3);
    check_eq("lzb_0000_digits", 32'(en_or2), 32'h1);
`else
    check_eq("no_lzb_0040_digits", 32'(en_or1), 32'hF);
    check_eq("no_lzb_0000_digits", 32'(en_or2), 32'hF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
